// File: rtl/referee_wrr.sv
// referee_wrr: weighted round-robin drain of NUM_CH source FIFOs, each word routed to the
// destination FIFO named by its destination field. Optional PUSH_COUNT_EN adds push_count.
module referee_wrr #(
  parameter int                  NUM_CH   = 4,
  parameter int                  DATA_W   = 12,
  parameter int                  DEST_LSB = 8,
  parameter logic [NUM_CH*4-1:0] WEIGHTS  = 16'h1234,
  parameter int                  CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_L,
  input  logic [3:0]                 state,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  input  logic [NUM_CH-1:0]          empty,
  input  logic [NUM_CH-1:0]          almost_full,
  output logic [NUM_CH-1:0]          pop,
  output logic [NUM_CH-1:0]          push,
  output logic [DATA_W-1:0]          data_out,
  output logic                       busy
`ifdef PUSH_COUNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]    push_count
`endif
);
  localparam int PW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int STAGES = 2;

  logic [PW-1:0]       ptr_q, ptr_d, src_q, gnt;
  logic [3:0]          wcnt_q, wcnt_d, wbase;
  logic [STAGES:1]     vld_pipe_q;
  logic                init, run, any_ne;
  logic [3:0]          wt_tab [NUM_CH];
  logic [DATA_W-1:0]   din [NUM_CH];
  logic [DATA_W-1:0]   word;
  logic [PW-1:0]       dest;
  logic [NUM_CH-1:0]   dest_oh;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    // A zero weight would starve the channel, so it counts as one pop per turn.
    assign wt_tab[i] = (WEIGHTS[i*4 +: 4] == 4'd0) ? 4'd1 : WEIGHTS[i*4 +: 4];
    assign din[i]    = data_in[i*DATA_W +: DATA_W];
  end

  // First non-empty channel strictly after 'from', ascending with wrap ('from' itself last).
  function automatic logic [PW-1:0] next_ne(input logic [PW-1:0] from,
                                            input logic [NUM_CH-1:0] emp);
    logic [PW-1:0] r, idx;
    r = from;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = PW'((int'(from) + k) % NUM_CH);
      if (!emp[idx]) r = idx;
    end
    return r;
  endfunction

  assign init   = (state == 4'b0001);
  assign run    = reset_L && ((state == 4'b0100) || (state == 4'b1000)) && !(|almost_full);
  assign any_ne = ~&empty;

  // An empty current channel hands its turn to the next backlogged one in the same cycle.
  always_comb begin
    pop    = '0;
    ptr_d  = ptr_q;
    wcnt_d = wcnt_q;
    gnt    = empty[ptr_q] ? next_ne(ptr_q, empty) : ptr_q;
    wbase  = empty[ptr_q] ? 4'd0 : wcnt_q;
    if (run && any_ne) begin
      pop[gnt] = 1'b1;
      if (wbase + 4'd1 == wt_tab[gnt]) begin
        ptr_d  = next_ne(gnt, empty);
        wcnt_d = '0;
      end else begin
        ptr_d  = gnt;
        wcnt_d = wbase + 4'd1;
      end
    end
  end

  assign word = din[src_q];
  assign dest = word[DEST_LSB +: PW];

  always_comb begin
    dest_oh = '0;
    for (int i = 0; i < NUM_CH; i++) dest_oh[i] = (dest == PW'(i));
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q      <= '0;
      wcnt_q     <= '0;
      src_q      <= '0;
      vld_pipe_q <= '0;
      push       <= '0;
      data_out   <= '0;
    end else if (init) begin
      ptr_q      <= '0;
      wcnt_q     <= '0;
      src_q      <= '0;
      vld_pipe_q <= '0;
      push       <= '0;
      data_out   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wcnt_q     <= wcnt_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], |pop};
      if (|pop) src_q <= gnt;
      // Source read data is valid the cycle after the pop; it goes straight to the output stage.
      push <= vld_pipe_q[1] ? dest_oh : '0;
      if (vld_pipe_q[1]) data_out <= word;
    end
  end

  assign busy = |vld_pipe_q;

`ifdef PUSH_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
    end else if (init) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (push[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign push_count = cnt_q;
`endif

endmodule

// File: tb/tb_referee_wrr.sv
// Directed bench for referee_wrr: single-word vector table plus WRR, routing, stall,
// empty-skip, reset and HOLD/INIT sequences against a behavioural source-FIFO model.
module tb_referee_wrr;
  localparam logic [3:0] S_INIT = 4'b0001, S_HOLD = 4'b0010, S_ACT = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  state;
  logic [47:0] data_in = '0;
  logic [3:0]  empty;
  logic [3:0]  almost_full;
  logic [3:0]  pop, push;
  logic [11:0] data_out;
  logic        busy;
`ifdef PUSH_COUNT_EN
  logic [63:0] push_count;
`endif

  referee_wrr dut (
    .clk(clk), .reset_L(reset_L), .state(state), .data_in(data_in), .empty(empty),
    .almost_full(almost_full), .pop(pop), .push(push), .data_out(data_out), .busy(busy)
`ifdef PUSH_COUNT_EN
    , .push_count(push_count)
`endif
  );

  always #5 clk = ~clk;

  // Source FIFO model: read data registered on the pop edge.
  logic [11:0] mem [4][64];
  logic [5:0]  rd [4] = '{default: '0};
  logic [5:0]  wr [4] = '{default: '0};

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (pop[i]) begin
        data_in[i*12 +: 12] <= mem[i][rd[i]];
        rd[i] <= rd[i] + 6'd1;
      end

  always_comb
    for (int i = 0; i < 4; i++) empty[i] = (rd[i] == wr[i]);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int ch, input int n);
    logic [1:0] d;
    d = 2'((ch + n) % 4);
    return {2'b00, d, 2'b00, 2'(ch), 4'(n)};
  endfunction

  function automatic logic [3:0] oh(input logic [11:0] w);
    return 4'b0001 << w[9:8];
  endfunction

  task automatic load(input int ch, input logic [11:0] w);
    mem[ch][wr[ch]] = w;
    wr[ch] = wr[ch] + 6'd1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) wr[i] = rd[i];
  endtask

  task automatic load_all(input int n);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < n; j++) load(c, mk(c, j));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0;
    state   = S_HOLD;
    @(negedge clk);
    reset_L = 1'b1;
    flush();
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    int          ch;
    logic [11:0] word;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
  } vec_t;

  vec_t        vecs [8];
  int          seq  [10];
  logic [11:0] exp_w [24];
  int          pc [4];
  logic [3:0]  e_pop [8];

  initial begin
    vecs[0] = '{0, 12'h1C3, 4'b0001, 4'b0010};
    vecs[1] = '{1, 12'h0F0, 4'b0010, 4'b0001};
    vecs[2] = '{2, 12'hE2F, 4'b0100, 4'b0100};
    vecs[3] = '{3, 12'h7FF, 4'b1000, 4'b1000};
    vecs[4] = '{3, 12'h400, 4'b1000, 4'b0001};
    vecs[5] = '{1, 12'hB5A, 4'b0010, 4'b1000};
    vecs[6] = '{0, 12'h200, 4'b0001, 4'b0100};
    vecs[7] = '{2, 12'hD00, 4'b0100, 4'b0010};
    seq = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

    reset_L = 1'b0; state = S_HOLD; almost_full = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pop", pop, 0);
    chk("reset_push", push, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", data_out, 0);
    @(negedge clk);
    reset_L = 1'b1;

    // Single-word vectors: pop, 2-cycle latency, routing, data hold.
    state = S_ACT;
    for (int v = 0; v < 8; v++) begin
      step(); flush(); load(vecs[v].ch, vecs[v].word); #1;
      chk($sformatf("v%0d_pop", v), pop, vecs[v].exp_pop);
      step(); #1;
      chk($sformatf("v%0d_pop_drained", v), pop, 0);
      chk($sformatf("v%0d_busy1", v), busy, 1);
      step(); #1;
      chk($sformatf("v%0d_push", v), push, vecs[v].exp_push);
      chk($sformatf("v%0d_data", v), data_out, vecs[v].word);
      step(); #1;
      chk($sformatf("v%0d_push_off", v), push, 0);
      chk($sformatf("v%0d_hold", v), data_out, vecs[v].word);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // WRR order with all sources backlogged, then HOLD drains the pipe.
    do_reset(); load_all(20);
    pc = '{0, 0, 0, 0};
    for (int k = 0; k < 23; k++) begin
      step();
      state = (k < 20) ? S_ACT : S_HOLD;
      #1;
      if (k < 20) begin
        chk($sformatf("wrr_pop%0d", k), pop, 4'b0001 << seq[k % 10]);
        exp_w[k] = mk(seq[k % 10], pc[seq[k % 10]]);
        pc[seq[k % 10]]++;
      end else chk($sformatf("hold_pop%0d", k), pop, 0);
      if (k >= 2 && k < 22) begin
        chk($sformatf("wrr_push%0d", k), push, oh(exp_w[k-2]));
        chk($sformatf("wrr_data%0d", k), data_out, exp_w[k-2]);
      end
      if (k == 22) chk("hold_busy", busy, 0);
    end

    // Asynchronous reset mid-stream, then the first pop is ch0.
    step(); state = S_ACT;
    repeat (2) step();
    #3; reset_L = 1'b0; #1;
    chk("t1_pop", pop, 0);
    chk("t1_push", push, 0);
    chk("t1_busy", busy, 0);
    step(); reset_L = 1'b1; #1;
    chk("t1_first_pop", pop, 4'b0001);

    // Routing: three ch2 words to destinations 3,0,1.
    do_reset();
    load(2, 12'h3C1); load(2, 12'h0C2); load(2, 12'h1C3);
    exp_w[0] = 12'h3C1; exp_w[1] = 12'h0C2; exp_w[2] = 12'h1C3;
    for (int k = 0; k < 5; k++) begin
      step(); state = S_ACT; #1;
      chk($sformatf("t3_pop%0d", k), pop, (k < 3) ? 4'b0100 : 4'b0000);
      if (k >= 2) begin
        chk($sformatf("t3_push%0d", k), push, oh(exp_w[k-2]));
        chk($sformatf("t3_data%0d", k), data_out, exp_w[k-2]);
      end
    end

    // Backpressure after two pops: both in-flight words land, WRR resumes where it froze.
    do_reset(); load_all(10);
    e_pop = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    for (int k = 0; k < 8; k++) begin
      step();
      state = S_ACT;
      almost_full = (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("t4_pop%0d", k), pop, e_pop[k]);
      if (k == 2) chk("t4_push2", push, oh(mk(0, 0)));
      if (k == 3) chk("t4_push3", push, oh(mk(0, 1)));
      if (k == 3) chk("t4_data3", data_out, mk(0, 1));
      if (k == 4) chk("t4_busy4", busy, 0);
      if (k == 7) chk("t4_push7", push, oh(mk(0, 2)));
    end

    // Empty skip: only ch3 backlogged, then ch0 refills and the pointer wraps to it.
    do_reset();
    for (int j = 0; j < 5; j++) load(3, mk(3, j));
    e_pop = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0001};
    for (int k = 0; k < 10; k++) begin
      step();
      state = S_ACT;
      if (k == 6) begin load(0, mk(0, 0)); load(0, mk(0, 1)); load(3, mk(3, 5)); end
      #1;
      if (k < 8) chk($sformatf("t5_pop%0d", k), pop, e_pop[k]);
      else chk($sformatf("t5_pop%0d", k), pop, (k == 8) ? 4'b0001 : 4'b0000);
      if (k == 2) chk("t5_push2", push, oh(mk(3, 0)));
    end

    // HOLD mid-stream, then INIT resets pointer and weight count, then INIT discards in-flight.
    do_reset(); load_all(10);
    for (int k = 0; k < 14; k++) begin
      step();
      case (k)
        3, 4, 5: state = S_HOLD;
        6, 12:   state = S_INIT;
        13:      state = S_HOLD;
        default: state = S_ACT;
      endcase
      #1;
      if (k < 3) chk($sformatf("t6_pop%0d", k), pop, 4'b0001);
      if (k == 3) chk("t6_hold_pop", pop, 0);
      if (k == 3) chk("t6_push3", push, oh(mk(0, 1)));
      if (k == 4) chk("t6_push4", push, oh(mk(0, 2)));
      if (k == 4) chk("t6_busy4", busy, 1);
      if (k == 5) chk("t6_busy5", busy, 0);
      if (k == 6) chk("t6_init_pop", pop, 0);
      if (k >= 7 && k <= 10) chk($sformatf("t6_pop%0d", k), pop, 4'b0001);
      if (k == 11) chk("t6_pop11", pop, 4'b0010);
      if (k == 13) begin
        chk("t6_init_busy", busy, 0);
        chk("t6_init_push", push, 0);
        chk("t6_init_data", data_out, 0);
`ifdef PUSH_COUNT_EN
        chk("t6_init_count", push_count[31:0], 0);
`endif
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
